ram_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 32x4 RAM and drives its address, data and wren ports. It also consumes the RAM's q output and feeds the HEX display stage.
- FILL mode: writes a 4-bit pattern into every location, one per clock.
- SCAN mode: steps through all addresses at a human-visible rate and presents each address/data pair for display.
- Replaces manual switch/KEY stepping of the RAM.

---
 rtl/ram_scan_if.sv | 61 ++++++
 rtl/ram_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ram_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_scan_if
//  Purpose  : Bundles the control, RAM-side and display-side signals of the
//             RAM scan sequencer into one interface.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters : ADDR_W (RAM address width), DATA_W (RAM word width)
//  Signals    : start/stop/mode/fill_value    control into the sequencer
//               ram_address/ram_data/ram_wren  sequencer to RAM
//               ram_q                          RAM to sequencer
//               disp_addr/disp_data/disp_valid sequencer to HEX display
//               busy/done                      status
//               err/err_addr                   only with RAM_SCAN_CHECK_EN
//  Modports   : master = sequencer side, slave = surrounding system side
// ============================================================================
interface ram_scan_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) ();
    logic              start;
    logic              stop;
    logic              mode;
    logic [DATA_W-1:0] fill_value;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              busy;
    logic              done;
`ifdef RAM_SCAN_CHECK_EN
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    modport master (
        input  start, stop, mode, fill_value, ram_q,
        output ram_address, ram_data, ram_wren,
        output disp_addr, disp_data, disp_valid, busy, done, err, err_addr
    );
    modport slave (
        output start, stop, mode, fill_value, ram_q,
        input  ram_address, ram_data, ram_wren,
        input  disp_addr, disp_data, disp_valid, busy, done, err, err_addr
    );
`else
    modport master (
        input  start, stop, mode, fill_value, ram_q,
        output ram_address, ram_data, ram_wren,
        output disp_addr, disp_data, disp_valid, busy, done
    );
    modport slave (
        output start, stop, mode, fill_value, ram_q,
        input  ram_address, ram_data, ram_wren,
        input  disp_addr, disp_data, disp_valid, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_scan_ctrl
//  Purpose  : Sequencer in front of a small synchronous RAM. FILL writes
//             pattern+address into every word, one per clock; SCAN reads the
//             words back in a loop and holds each on the display for TICK_DIV
//             clocks.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports    : clock  system clock (posedge)
//             reset  synchronous active-high reset
//             bus    ram_scan_if.master (control, RAM, display, status)
//  Option   : RAM_SCAN_CHECK_EN adds err/err_addr; SCAN captures are compared
//             against the pattern of the last FILL.
// ============================================================================
module ram_scan_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int RD_LAT   = 1
) (
    input wire         clock,
    input wire         reset,
    ram_scan_if.master bus
);
    localparam int c_TICK_W = $clog2(TICK_DIV + 1);
    localparam int c_LAT_W  = $clog2(RD_LAT + 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_LAT_W-1:0]  c_LAT_LAST  = c_LAT_W'(RD_LAT);
    localparam logic [ADDR_W-1:0]   c_ADDR_LAST = '1;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_FILL      = 2'd1;
    localparam logic [1:0] c_SCAN_RD   = 2'd2;
    localparam logic [1:0] c_SCAN_HOLD = 2'd3;

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_pattern;
    logic [c_LAT_W-1:0]  r_lat;
    logic [c_TICK_W-1:0] r_tick;
    logic [ADDR_W-1:0]   r_ram_address;
    logic [DATA_W-1:0]   r_ram_data;
    logic                r_ram_wren;
    logic [ADDR_W-1:0]   r_disp_addr;
    logic [DATA_W-1:0]   r_disp_data;
    logic                r_disp_valid;
    logic                r_busy;
    logic                r_done;

    logic [ADDR_W-1:0]   w_cnt_inc;
    logic                w_start_ok;

    assign w_cnt_inc  = r_cnt + ADDR_W'(1);
    // stop beats start when both arrive together in IDLE
    assign w_start_ok = bus.start && !bus.stop;

`ifdef RAM_SCAN_CHECK_EN
    logic                r_chk_en;
    logic                r_err;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [DATA_W-1:0]   w_expect;

    assign w_expect     = r_pattern + DATA_W'(r_cnt);
    assign bus.err      = r_err;
    assign bus.err_addr = r_err_addr;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_pattern     <= '0;
            r_lat         <= '0;
            r_tick        <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
            r_disp_addr   <= '0;
            r_disp_data   <= '0;
            r_disp_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
`ifdef RAM_SCAN_CHECK_EN
            r_chk_en      <= 1'b0;
            r_err         <= 1'b0;
            r_err_addr    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_start_ok) begin
                        r_cnt         <= '0;
                        r_ram_address <= '0;
                        r_busy        <= 1'b1;
`ifdef RAM_SCAN_CHECK_EN
                        r_err         <= 1'b0;
                        r_err_addr    <= '0;
`endif
                        if (bus.mode) begin
                            // first write is issued straight from the start edge
                            r_state    <= c_FILL;
                            r_pattern  <= bus.fill_value;
                            r_ram_data <= bus.fill_value;
                            r_ram_wren <= 1'b1;
`ifdef RAM_SCAN_CHECK_EN
                            r_chk_en   <= 1'b1;
`endif
                        end else begin
                            r_state    <= c_SCAN_RD;
                            r_ram_data <= '0;
                            r_lat      <= '0;
                        end
                    end
                end

                c_FILL: begin
                    if (r_cnt == c_ADDR_LAST) begin
                        r_ram_wren <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= c_IDLE;
                    end else begin
                        r_cnt         <= w_cnt_inc;
                        r_ram_address <= w_cnt_inc;
                        r_ram_data    <= r_pattern + DATA_W'(w_cnt_inc);
                    end
                end

                c_SCAN_RD: begin
                    if (bus.stop) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_lat == c_LAT_LAST) begin
                        // ram_q now reflects the address presented on entry
                        r_disp_addr  <= r_cnt;
                        r_disp_data  <= bus.ram_q;
                        r_disp_valid <= 1'b1;
                        r_tick       <= '0;
                        r_state      <= c_SCAN_HOLD;
`ifdef RAM_SCAN_CHECK_EN
                        if (r_chk_en && !r_err && (bus.ram_q != w_expect)) begin
                            r_err      <= 1'b1;
                            r_err_addr <= r_cnt;
                        end
`endif
                    end else begin
                        r_lat <= r_lat + c_LAT_W'(1);
                    end
                end

                c_SCAN_HOLD: begin
                    if (bus.stop) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_tick == c_TICK_LAST) begin
                        // counter wraps naturally at 2**ADDR_W
                        r_cnt         <= w_cnt_inc;
                        r_ram_address <= w_cnt_inc;
                        r_lat         <= '0;
                        r_state       <= c_SCAN_RD;
                    end else begin
                        r_tick <= r_tick + c_TICK_W'(1);
                    end
                end

                default: begin
                    r_state    <= c_IDLE;
                    r_busy     <= 1'b0;
                    r_ram_wren <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_address = r_ram_address;
    assign bus.ram_data    = r_ram_data;
    assign bus.ram_wren    = r_ram_wren;
    assign bus.disp_addr   = r_disp_addr;
    assign bus.disp_data   = r_disp_data;
    assign bus.disp_valid  = r_disp_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_scan_ctrl
//  Purpose  : Directed self-checking bench for ram_scan_ctrl with a 32x4
//             synchronous RAM model (TICK_DIV=4, RD_LAT=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_scan_ctrl;
    localparam int c_ADDR_W = 5;
    localparam int c_DATA_W = 4;

    logic clock;
    logic reset;
    logic mem_clr;
    logic corrupt;
    int   n_chk;
    int   n_err;
    int   done_cnt;

    logic [c_DATA_W-1:0] mem [32];

    ram_scan_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

    ram_scan_ctrl #(
        .ADDR_W  (c_ADDR_W),
        .DATA_W  (c_DATA_W),
        .TICK_DIV(4),
        .RD_LAT  (1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: registered read; reads of word 7 can be corrupted on demand
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (bus.ram_wren) begin
            mem[bus.ram_address] <= bus.ram_data;
        end
        bus.ram_q <= mem[bus.ram_address] ^
                     ((corrupt && bus.ram_address == 5'd7) ? 4'hA : 4'h0);
    end

    always @(posedge clock) begin
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_disp(input logic [4:0] a, input int budget);
        int k;
        k = 0;
        while (!(bus.disp_valid === 1'b1 && bus.disp_addr === a) && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("disp_wait", 32'(k < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ea;
        logic [3:0] ed;
        int         k;
        n_chk      = 0;
        n_err      = 0;
        done_cnt   = 0;
        corrupt    = 1'b0;
        mem_clr    = 1'b1;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.mode   = 1'b0;
        bus.fill_value = '0;

        // ---------------- reset state
        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_wren", bus.ram_wren, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.disp_valid, 0);
        check("rst_addr", bus.ram_address, 0);
`ifdef RAM_SCAN_CHECK_EN
        check("rst_err", bus.err, 0);
`endif
        reset   = 1'b0;
        mem_clr = 1'b0;

        // ---------------- reset in the middle of a FILL (pattern 5)
        bus.start = 1'b1; bus.mode = 1'b1; bus.fill_value = 4'h5;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        check("midfill_addr", bus.ram_address, 4);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_wren", bus.ram_wren, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_addr", bus.ram_address, 0);
        check("midrst_data", bus.ram_data, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("midrst_nodone", done_cnt, 0);
        check("midrst_mem4", mem[4], 4'h9);
        check("midrst_mem5", mem[5], 4'h0);

        // ---------------- FILL with pattern 3
        bus.start = 1'b1; bus.mode = 1'b1; bus.fill_value = 4'h3;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (i == 0) bus.start = 1'b0;
            ed = 4'(3 + i);
            check("fill_wren", bus.ram_wren, 1);
            check("fill_addr", bus.ram_address, i);
            check("fill_data", bus.ram_data, ed);
        end
        @(negedge clock);
        check("fill_done", bus.done, 1);
        check("fill_wren_off", bus.ram_wren, 0);
        check("fill_busy_off", bus.busy, 0);
        @(negedge clock);
        check("fill_done_pulse", bus.done, 0);
        check("fill_done_cnt", done_cnt, 1);
        check("fill_mem31", mem[31], 4'h2);

        // ---------------- SCAN: first capture two cycles after start
        bus.start = 1'b1; bus.mode = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        check("scan_busy", bus.busy, 1);
        check("scan_valid_early", bus.disp_valid, 0);
        @(negedge clock);
        @(negedge clock);
        check("scan0_valid", bus.disp_valid, 1);
        check("scan0_addr", bus.disp_addr, 0);
        check("scan0_data", bus.disp_data, 4'h3);
        // 4-cycle hold plus 2-cycle read: a new word every 6 cycles
        for (int a = 1; a <= 37; a++) begin
            repeat (5) @(negedge clock);
            ea = 5'(a - 1);
            check("scan_hold", bus.disp_addr, ea);
            @(negedge clock);
            ea = 5'(a);
            ed = 4'(3 + a);
            check("scan_addr", bus.disp_addr, ea);
            check("scan_data", bus.disp_data, ed);
            check("scan_wren", bus.ram_wren, 0);
        end

        // ---------------- stop while holding address 5
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        check("stop_busy", bus.busy, 0);
        check("stop_addr", bus.disp_addr, 5);
        check("stop_data", bus.disp_data, 4'h8);
        check("stop_valid", bus.disp_valid, 1);
        repeat (10) @(negedge clock);
        check("stop_stay_addr", bus.disp_addr, 5);
        check("stop_stay_busy", bus.busy, 0);

        // ---------------- start during FILL is ignored
        bus.start = 1'b1; bus.mode = 1'b1; bus.fill_value = 4'h3;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        bus.start = 1'b1; bus.mode = 1'b0; bus.fill_value = 4'h9;
        @(negedge clock);
        bus.start = 1'b0;
        check("ign_addr", bus.ram_address, 10);
        check("ign_data", bus.ram_data, 4'hD);
        check("ign_wren", bus.ram_wren, 1);
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("ign_done_cycles", k, 22);
        @(negedge clock);
        check("ign_idle", bus.busy, 0);

        // ---------------- start and stop together in IDLE
        k = done_cnt;
        bus.start = 1'b1; bus.stop = 1'b1; bus.mode = 1'b1;
        @(negedge clock);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("ss_busy", bus.busy, 0);
        check("ss_wren", bus.ram_wren, 0);
        @(negedge clock);
        check("ss_busy2", bus.busy, 0);
        check("ss_wren2", bus.ram_wren, 0);
        check("ss_done", done_cnt, k);

`ifdef RAM_SCAN_CHECK_EN
        // ---------------- readback check with a corrupted word 7
        bus.start = 1'b1; bus.mode = 1'b1; bus.fill_value = 4'h0;
        @(negedge clock);
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("chk_fill_done", bus.done, 1);
        corrupt = 1'b1;
        bus.start = 1'b1; bus.mode = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        wait_disp(5'd6, 60);
        check("chk_err6", bus.err, 0);
        wait_disp(5'd7, 20);
        check("chk_data7", bus.disp_data, 4'hD);
        check("chk_err7", bus.err, 1);
        check("chk_erraddr7", bus.err_addr, 7);
        wait_disp(5'd0, 200);
        wait_disp(5'd1, 20);
        check("chk_err_wrap", bus.err, 1);
        check("chk_erraddr_wrap", bus.err_addr, 7);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        bus.start = 1'b1; bus.mode = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        check("chk_err_clr", bus.err, 0);
        check("chk_erraddr_clr", bus.err_addr, 0);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        corrupt = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
